// File: rtl/ub_pkg.sv
// Address split and byte-parity helpers shared by the banked unified buffer.
package ub_pkg;

    typedef logic [7:0] ub_byte_t;

    // Low-order interleave: the bank is the low bits of the word address.
    function automatic logic [31:0] ub_bank(input logic [31:0] addr, input int bank_bits);
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] ub_row(input logic [31:0] addr, input int bank_bits);
        return addr >> bank_bits;
    endfunction

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic ub_byte_par(input ub_byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/ub_rsp_fifo.sv
// Two-entry in-order response FIFO; head is forced to zero while empty.
module ub_rsp_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [1:0]       count_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] entry_q [2];
    logic             head_q;
    logic [1:0]       count_q;
    logic             tail;

    assign tail = head_q ^ count_q[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (pop_i) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            entry_q[tail] <= data_i;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = valid_o ? entry_q[head_q] : '0;

endmodule

// File: rtl/unified_buffer_banked.sv
// Banked, byte-strobed unified buffer with a 2-deep read response FIFO.
// Optional per-byte parity storage and error report when UB_PARITY_EN is defined.
module unified_buffer_banked
    import ub_pkg::*;
#(
    parameter  int SA_LENGTH  = 256,
    parameter  int ADDR_WIDTH = 10,
    parameter  int NO_BANKS   = 8,
    localparam int BANK_BITS  = $clog2(NO_BANKS),
    localparam int WORD_AW    = ADDR_WIDTH + BANK_BITS,
    localparam int DW         = 8 * SA_LENGTH
) (
    input  logic                 CLK,
    input  logic                 SYNC_RST,
    input  logic                 EN,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD_AW-1:0]   wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [SA_LENGTH-1:0] wr_strb,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [WORD_AW-1:0]   rd_addr,
    output logic                 rd_rsp_valid,
    input  logic                 rd_rsp_ready,
    output logic [DW-1:0]        rd_data
`ifdef UB_PARITY_EN
    ,
    output logic                 rd_perr,
    input  logic                 perr_inject
`endif
);

    localparam int ROWS = 2 ** ADDR_WIDTH;
`ifdef UB_PARITY_EN
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif

    logic [BANK_BITS-1:0]  wr_bank, rd_bank;
    logic [ADDR_WIDTH-1:0] wr_row, rd_row;
    logic                  conflict, wr_fire, rd_fire, pop;
    logic [1:0]            fifo_count;
    logic [DW-1:0]         rd_word;
    logic [EW-1:0]         push_entry, head_entry;

    ub_byte_t mem_q [NO_BANKS][ROWS][SA_LENGTH];

    assign wr_bank = BANK_BITS'(ub_bank(32'(wr_addr), BANK_BITS));
    assign rd_bank = BANK_BITS'(ub_bank(32'(rd_addr), BANK_BITS));
    assign wr_row  = ADDR_WIDTH'(ub_row(32'(wr_addr), BANK_BITS));
    assign rd_row  = ADDR_WIDTH'(ub_row(32'(rd_addr), BANK_BITS));

    // A bank has one port per cycle; a pending write always beats a read.
    assign conflict     = wr_valid & rd_req_valid & (wr_bank == rd_bank);
    assign wr_ready     = EN & ~SYNC_RST;
    assign rd_req_ready = EN & ~SYNC_RST & ~conflict & (fifo_count < 2'd2);
    assign wr_fire      = wr_valid & wr_ready;
    assign rd_fire      = rd_req_valid & rd_req_ready;
    assign pop          = rd_rsp_valid & rd_rsp_ready & EN & ~SYNC_RST;

    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            for (int i = 0; i < SA_LENGTH; i++) begin
                if (wr_strb[i]) begin
                    mem_q[wr_bank][wr_row][i] <= wr_data[8*i +: 8];
                end
            end
        end
    end

`ifdef UB_PARITY_EN
    logic par_q [NO_BANKS][ROWS][SA_LENGTH];
    logic rd_err;

    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            for (int i = 0; i < SA_LENGTH; i++) begin
                if (wr_strb[i]) begin
                    par_q[wr_bank][wr_row][i] <= ub_byte_par(wr_data[8*i +: 8]) ^ perr_inject;
                end
            end
        end
    end

    always_comb begin
        rd_err = 1'b0;
        for (int i = 0; i < SA_LENGTH; i++) begin
            rd_err = rd_err | (ub_byte_par(mem_q[rd_bank][rd_row][i]) ^ par_q[rd_bank][rd_row][i]);
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < SA_LENGTH; i++) begin
            rd_word[8*i +: 8] = mem_q[rd_bank][rd_row][i];
        end
    end

`ifdef UB_PARITY_EN
    assign push_entry = {rd_err, rd_word};
`else
    assign push_entry = rd_word;
`endif

    ub_rsp_fifo #(
        .WIDTH (EW)
    ) u_rsp_fifo (
        .clk_i   (CLK),
        .rst_i   (SYNC_RST),
        .push_i  (rd_fire),
        .pop_i   (pop),
        .data_i  (push_entry),
        .count_o (fifo_count),
        .valid_o (rd_rsp_valid),
        .data_o  (head_entry)
    );

    assign rd_data = head_entry[DW-1:0];
`ifdef UB_PARITY_EN
    assign rd_perr = head_entry[DW];
`endif

endmodule

// File: tb/tb_unified_buffer_banked.sv
// Self-checking bench for unified_buffer_banked (SA_LENGTH=4, ADDR_WIDTH=4, NO_BANKS=2).
module tb_unified_buffer_banked;

    localparam int SA  = 4;
    localparam int AW  = 4;
    localparam int NB  = 2;
    localparam int WAW = 5;
    localparam int DW  = 32;
    localparam int NW  = 32;

    logic          CLK = 1'b0;
    logic          SYNC_RST, EN;
    logic          wr_valid, wr_ready;
    logic [WAW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SA-1:0] wr_strb;
    logic          rd_req_valid, rd_req_ready;
    logic [WAW-1:0] rd_addr;
    logic          rd_rsp_valid, rd_rsp_ready;
    logic [DW-1:0] rd_data;
`ifdef UB_PARITY_EN
    logic          rd_perr;
    logic          perr_inject;
`endif

    always #5 CLK = ~CLK;

    unified_buffer_banked #(
        .SA_LENGTH  (SA),
        .ADDR_WIDTH (AW),
        .NO_BANKS   (NB)
    ) dut (
        .CLK          (CLK),
        .SYNC_RST     (SYNC_RST),
        .EN           (EN),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr      (rd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_data      (rd_data)
`ifdef UB_PARITY_EN
        ,
        .rd_perr      (rd_perr),
        .perr_inject  (perr_inject)
`endif
    );

    // Reference model: word array, per-byte corrupted-parity flags, queue of pending responses.
    logic [31:0] ref_mem [NW];
    bit          ref_bad [NW][SA];
    logic [32:0] exp_q [$];
    bit          rst_empty;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hold;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_any(input int a);
        bit r = 1'b0;
        for (int b = 0; b < SA; b++) r |= ref_bad[a][b];
        return r;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        bit act, conf, exp_rrdy;
        logic [32:0] ent;
        @(negedge CLK);
        act      = EN && !SYNC_RST;
        conf     = wr_valid && rd_req_valid && ((int'(wr_addr) % NB) == (int'(rd_addr) % NB));
        exp_rrdy = act && !conf && (exp_q.size() < 2);
        check_val("wr_ready", wr_ready, act);
        check_val("rd_req_ready", rd_req_ready, exp_rrdy);
        check_val("rd_rsp_valid", rd_rsp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_val("rd_data", rd_data, exp_q[0][31:0]);
`ifdef UB_PARITY_EN
            check_val("rd_perr", rd_perr, exp_q[0][32]);
`endif
        end else if (rst_empty) begin
            check_val("rd_data_rst", rd_data, 0);
`ifdef UB_PARITY_EN
            check_val("rd_perr_rst", rd_perr, 0);
`endif
        end
        @(posedge CLK);
        if (SYNC_RST) begin
            exp_q.delete();
            rst_empty = 1'b1;
        end else if (EN) begin
            ent = {bad_any(int'(rd_addr)), ref_mem[rd_addr]};
            if (exp_q.size() != 0 && rd_rsp_ready) void'(exp_q.pop_front());
            if (rd_req_valid && exp_rrdy) begin
                exp_q.push_back(ent);
                rst_empty = 1'b0;
            end
            if (wr_valid) begin
                for (int b = 0; b < SA; b++) begin
                    if (wr_strb[b]) begin
                        ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
`ifdef UB_PARITY_EN
                        ref_bad[wr_addr][b] = perr_inject;
`else
                        ref_bad[wr_addr][b] = 1'b0;
`endif
                    end
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit wv, input int wa, input logic [31:0] wd, input logic [3:0] ws,
                         input bit rv, input int ra, input bit rr);
        wr_valid     = wv;
        wr_addr      = WAW'(wa);
        wr_data      = wd;
        wr_strb      = ws;
        rd_req_valid = rv;
        rd_addr      = WAW'(ra);
        rd_rsp_ready = rr;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        SYNC_RST = 1'b1;
        EN       = 1'b1;
        rst_empty = 1'b1;
`ifdef UB_PARITY_EN
        perr_inject = 1'b0;
`endif
        for (int a = 0; a < NW; a++) begin
            ref_mem[a] = '0;
            for (int b = 0; b < SA; b++) ref_bad[a][b] = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        @(posedge CLK);
        #1;
        cycle();
        cycle();
        SYNC_RST = 1'b0;

        for (int a = 0; a < NW; a++) begin
            drive(1, a, $urandom, 4'hF, 0, 0, 1);
            cycle();
        end

        // Partial strobe merge, then read back.
        drive(1, 5, 32'h44332211, 4'hF, 0, 0, 1); cycle();
        drive(1, 5, 32'h0000AA00, 4'h2, 0, 0, 1); cycle();
        drive(0, 0, 0, 0, 1, 5, 1); cycle();
        check_val("merge_valid", rd_rsp_valid, 1);
        check_val("merge_data", rd_data, 32'h4433AA11);
        drive(0, 0, 0, 0, 0, 0, 1); cycle();

        // Bank conflict, then retry, then different banks together.
        drive(1, 4, $urandom, 4'hF, 1, 6, 1); cycle();
        check_val("conflict_ready", rd_req_ready, 0);
        drive(0, 0, 0, 0, 1, 6, 1); cycle();
        drive(1, 4, $urandom, 4'hF, 1, 7, 1); cycle();
        drive(0, 0, 0, 0, 1, 4, 1); cycle();
        drive(0, 0, 0, 0, 0, 0, 1); cycle(); cycle();

        // Backpressure: two queued, third stalls, head holds.
        drive(0, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 1, 0); cycle();
        drive(0, 0, 0, 0, 1, 2, 0); cycle();
        check_val("full_stall", rd_req_ready, 0);
        check_val("full_head", rd_data, ref_mem[0]);
        cycle(); cycle();
        check_val("full_hold", rd_data, ref_mem[0]);
        drive(0, 0, 0, 0, 1, 2, 1); cycle(); cycle();
        drive(0, 0, 0, 0, 0, 0, 1); cycle(); cycle(); cycle();

        // Reset flushes queued responses but not the array.
        drive(0, 0, 0, 0, 1, 8, 0); cycle();
        drive(0, 0, 0, 0, 1, 9, 0); cycle();
        SYNC_RST = 1'b1;
        drive(1, 5, 32'hDEADBEEF, 4'hF, 1, 10, 0); cycle();
        SYNC_RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        check_val("rst_valid", rd_rsp_valid, 0);
        check_val("rst_data", rd_data, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 5, 1); cycle();
        check_val("rst_keep_array", rd_data, 32'h4433AA11);
        drive(0, 0, 0, 0, 0, 0, 1); cycle();

        // Enable low freezes everything.
        drive(0, 0, 0, 0, 1, 10, 0); cycle();
        hold = rd_data;
        EN = 1'b0;
        drive(1, 11, 32'hCAFEF00D, 4'hF, 1, 12, 1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_val("en_hold_data", rd_data, hold);
            check_val("en_hold_valid", rd_rsp_valid, 1);
        end
        EN = 1'b1;
        cycle();
        drive(0, 0, 0, 0, 1, 11, 1); cycle();
        drive(0, 0, 0, 0, 0, 0, 1); cycle(); cycle(); cycle();

`ifdef UB_PARITY_EN
        perr_inject = 1'b1;
        drive(1, 3, 32'h12345678, 4'hF, 0, 0, 1); cycle();
        perr_inject = 1'b0;
        drive(0, 0, 0, 0, 1, 3, 1); cycle();
        check_val("perr_set", rd_perr, 1);
        drive(1, 3, 32'h12345678, 4'hF, 0, 0, 1); cycle();
        drive(0, 0, 0, 0, 1, 3, 1); cycle();
        check_val("perr_clear", rd_perr, 0);
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
`endif

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            EN       = ($urandom_range(0, 9) != 0);
            SYNC_RST = ($urandom_range(0, 59) == 0);
`ifdef UB_PARITY_EN
            perr_inject = ($urandom_range(0, 7) == 0);
`endif
            drive($urandom_range(0, 1), $urandom_range(0, NW - 1), $urandom, 4'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, NW - 1), ($urandom_range(0, 3) != 0));
            cycle();
        end
        SYNC_RST = 1'b0;
        EN = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle(); cycle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_buffer_banked.md
UNIFIED_BUFFER_BANKED -- requirements
Module: unified_buffer_banked

Interface
REQ-001 SHALL have parameter SA_LENGTH, default 256, bytes per word; DataWidth=8*SA_LENGTH, BytesPerWord=SA_LENGTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-index width per bank.
REQ-003 SHALL have parameter NO_BANKS, default 8, power of two >=2; WordAddrWidth=ADDR_WIDTH+$clog2(NO_BANKS).
REQ-004 SHALL use one clock; reset is synchronous and active-high: CLK and SYNC_RST.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 SYNC_RST  input  1  synchronous active-high reset.
REQ-007 EN  input  1  global enable; low freezes all state.
REQ-008 wr_valid, wr_ready  input/output  1 each  write handshake.
REQ-009 wr_addr  input  WordAddrWidth  word address; wr_data  input  DataWidth; wr_strb  input  BytesPerWord  byte enables.
REQ-010 rd_req_valid, rd_req_ready  input/output  1 each; rd_addr  input  WordAddrWidth.
REQ-011 rd_rsp_valid  output  1; rd_rsp_ready  input  1; rd_data  output  DataWidth.

Function
REQ-012 Bank SHALL be wr_addr/rd_addr[$clog2(NO_BANKS)-1:0] (low-order interleave); row SHALL be remaining upper ADDR_WIDTH bits.
REQ-013 Write SHALL occur on the edge where wr_valid & wr_ready; only bytes with wr_strb[i]=1 update; wr_strb=0 is a legal no-op.
REQ-014 wr_ready SHALL equal EN & !SYNC_RST (combinational).
REQ-015 Read request SHALL be accepted on the edge where rd_req_valid & rd_req_ready; array read happens on that edge.
REQ-016 Bank conflict (wr_valid & rd_req_valid & same bank) SHALL drop rd_req_ready that cycle; write wins, read retries.
REQ-017 rd_req_ready SHALL equal EN & !SYNC_RST & !conflict & (rsp FIFO count < 2).
REQ-018 Accepted read data SHALL enter a 2-entry in-order response FIFO; rd_rsp_valid asserts the cycle after acceptance (1-cycle latency).
REQ-019 rd_rsp_valid SHALL equal FIFO non-empty; rd_data SHALL show head entry, stable while rd_rsp_valid & !rd_rsp_ready.
REQ-020 Pop SHALL occur on edge where rd_rsp_valid & rd_rsp_ready & EN; simultaneous push and pop SHALL keep count.
REQ-021 Read accepted the edge after a write to the same address SHALL return new data; write and read to different banks in one cycle SHALL both complete.
REQ-022 EN low SHALL block all accepts and pops; FIFO, outputs and array hold.
REQ-023 Reads to never-written locations SHALL return unspecified data (no X-propagation requirement).

Reset
REQ-024 SYNC_RST high at an edge SHALL empty the FIFO: rd_rsp_valid=0, rd_data=0; in-flight responses are discarded.
REQ-025 Array contents SHALL NOT be reset; writes and reads are blocked while SYNC_RST high, regardless of EN.

Configuration
REQ-026 Macro UB_PARITY_EN SHALL add per-byte even-parity storage written with each strobed byte.
REQ-027 With UB_PARITY_EN: ports rd_perr output 1 (valid with rd_rsp_valid, 1 if any byte of head fails parity, reset 0) and perr_inject input 1 (inverts stored parity of bytes written that edge).
REQ-028 Without UB_PARITY_EN: no parity storage, no rd_perr/perr_inject ports; behaviour otherwise identical.

Structure
REQ-029 Package ub_pkg SHALL hold bank/row extraction functions and byte-parity function.
REQ-030 Sub-module ub_rsp_fifo SHALL implement the 2-entry response FIFO (parametrised width, includes parity flag when enabled).

Verification (SA_LENGTH=4, ADDR_WIDTH=4, NO_BANKS=2)
REQ-031 Write 0x44332211 strb 0xF addr 5, then strb 0x2 data 0x0000AA00 addr 5, read 5 -> rd_data 0x4433AA11 one cycle after accept.
REQ-032 Same-cycle write addr 4, read addr 6 (bank 0) -> rd_req_ready=0, write done; next cycle read accepted; write addr 4 + read addr 7 -> both accepted.
REQ-033 Three reads with rd_rsp_ready=0 -> two accepted, third stalls rd_req_ready=0, rd_data holds first; release -> in-order delivery, no loss.
REQ-034 SYNC_RST pulse with two responses queued -> rd_rsp_valid=0, rd_data=0 next cycle; later read of addr 5 still returns 0x4433AA11.
REQ-035 EN=0 for 3 cycles with valid requests -> no accepts, outputs stable; EN=1 resumes.
REQ-036 UB_PARITY_EN: write addr 3 with perr_inject=1, read 3 -> rd_perr=1; rewrite normally -> rd_perr=0.
